fb_access_arbiter: RTL and testbench
====================================

Name: fb_access_arbiter

Overview:
- Shares the single-port synchronous frame-buffer RAM between two requesters:
  - the VGA pixel fetcher, which has hard real-time priority;
  - the game-logic/CPU port, a req/ack handshake used for sprite and track updates.
- Sits between the VGA timing/pixel pipeline and the frame-buffer RAM inside the kart top level.
- Gives a fixed read latency to VGA and best-effort access to the CPU, plus a contention statistic.

Parameters:
- ADDR_W, 16, frame-buffer address width.
- DATA_W, 16, frame-buffer word width.
- CNT_W, 16, width of the contention counter.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- vga_rd_req  in  1  pixel fetch request, one cycle per word.
- vga_rd_addr  in  ADDR_W  pixel fetch address.
- vga_rd_data  out  DATA_W  fetched word.
- vga_rd_valid  out  1  vga_rd_data valid strobe.
- vga_blank_n  in  1  active-video flag from VGA timing; 0 = blanking.
- cpu_req  in  1  CPU access request, held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  RAM enable, combinational.
- mem_we  out  1  RAM write enable, combinational.
- mem_addr  out  ADDR_W  RAM address, combinational.
- mem_wdata  out  DATA_W  RAM write data, combinational.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read issue.
- contention_cnt  out  CNT_W  saturating count of denied CPU cycles.

Behaviour:

Reset (reset=0, asynchronous):
- Outputs cleared: vga_rd_valid=0, vga_rd_data=0, cpu_ack=0, cpu_rdata=0, contention_cnt=0.
- FSM goes to C_IDLE; the holding registers are cleared.
- mem_en=0 and mem_we=0 while in reset.

Reset mid-operation:
- Any pending CPU request is dropped; no ack is generated.
- An in-flight VGA read produces no vga_rd_valid.
- The requester must re-issue after reset releases.

Arbitration (evaluated every cycle):
- Priority 1, VGA: if vga_rd_req=1, issue a VGA read that cycle (mem_en=1, mem_we=0, mem_addr=vga_rd_addr).
- Priority 2, CPU: otherwise, if the FSM is in C_WAIT and the CPU is eligible, issue from the holding registers. This is the grant cycle.
- Otherwise mem_en=0.

VGA read latency:
- vga_rd_req in cycle N gives vga_rd_valid=1 in cycle N+2, with vga_rd_data = mem_rdata sampled in N+1, registered.
- Back-to-back requests every cycle give back-to-back valids, same order, no gaps.

CPU FSM:
- C_IDLE:
  - cpu_req=1 captures cpu_we, cpu_addr and cpu_wdata into the holding registers, then moves to C_WAIT.
  - CPU inputs are ignored in every other state.
- C_WAIT:
  - On a grant cycle: a write goes to C_ACK; a read goes to C_RDATA.
  - Each non-grant cycle in C_WAIT increments contention_cnt, saturating at 2^CNT_W-1.
- C_RDATA: register mem_rdata into cpu_rdata, then go to C_ACK.
- C_ACK: cpu_ack=1 for exactly one cycle, then go to C_IDLE.

CPU handshake rules:
- Write granted in cycle G: ack in G+1.
- Read granted in cycle G: ack in G+2, with cpu_rdata holding the word at the held address.
- Minimum CPU latency from cpu_req high in C_IDLE:
  - write: 3 cycles (capture, grant, ack);
  - read: 4 cycles.
- The requester deasserts cpu_req in the cycle after cpu_ack.
- cpu_rdata holds its value until the next read completes.

Simultaneous events:
- A VGA request in the would-be grant cycle always wins; the CPU stays in C_WAIT and is counted.
- No fairness guarantee: continuous vga_rd_req starves the CPU indefinitely.
- A CPU write and a VGA read to the same address in different cycles are ordered by issue cycle; the RAM defines the data.

Optional Feature:
- Macro: FB_VBLANK_WRITE_EN.
- Defined:
  - CPU writes are eligible only when vga_blank_n=0.
  - A write in C_WAIT during active video counts as contention.
  - CPU reads are unaffected.
  - This prevents mid-frame tearing.
- Undefined:
  - vga_blank_n is ignored (input left unconnected internally).
  - Writes are eligible whenever vga_rd_req=0.

Test Plan:
- Reset/idle: reset=0 then 1, no requests for 5 cycles -> all outputs 0; mem_en=0; contention_cnt=0.
- VGA stream: vga_rd_req=1 for 8 cycles at addrs 0x0100..0x0107, RAM model holding data=addr -> vga_rd_valid high cycles N+2..N+9, data 0x0100..0x0107 in order.
- CPU write uncontended: cpu_req=1, we=1, addr=0x1234, wdata=0xBEEF -> mem_we=1 with addr 0x1234 and data 0xBEEF one cycle after capture; cpu_ack the next cycle; contention_cnt=0.
- CPU read under contention: cpu read of 0x0042 (RAM=0x5A5A) while vga_rd_req is held for 6 cycles -> no CPU issue during those cycles; contention_cnt=6; grant on the first idle cycle; ack 2 cycles later with cpu_rdata=0x5A5A.
- Mid-operation reset: pulse reset low while the CPU is in C_WAIT and a VGA read is in flight -> no cpu_ack, no vga_rd_valid; FSM back in C_IDLE; contention_cnt=0.
- FB_VBLANK_WRITE_EN defined, vga_blank_n=1 for 10 cycles then 0, CPU write pending -> write issues only in the first cycle with blank_n=0; contention_cnt=10. With the macro undefined -> write issues immediately.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter: VGA pixel fetch has fixed priority, the CPU gets leftover cycles.
// Define FB_VBLANK_WRITE_EN to restrict CPU writes to blanking (vga_blank_n=0).
module fb_access_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic              vga_rd_valid,
    input  logic              vga_blank_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  contention_cnt
);
    localparam int STAGES = 1;

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RDATA, C_ACK} cpu_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cpu_txn_t;

    cpu_state_t      state, state_nxt;
    cpu_txn_t        held;
    logic [STAGES:0] vld_pipe;
    logic            cpu_elig;
    logic            grant;

`ifdef FB_VBLANK_WRITE_EN
    // writes wait for blanking so a frame is never scanned half-updated
    assign cpu_elig = !held.we || !vga_blank_n;
`else
    logic unused_blank_n;
    assign unused_blank_n = vga_blank_n;
    assign cpu_elig       = 1'b1;
`endif

    assign grant = (state == C_WAIT) && !vga_rd_req && cpu_elig;

    // RAM port is combinational; gated by reset so the RAM stays idle while reset is held
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (vga_rd_req) begin
                mem_en   = 1'b1;
                mem_addr = vga_rd_addr;
            end else if (grant) begin
                mem_en    = 1'b1;
                mem_we    = held.we;
                mem_addr  = held.addr;
                mem_wdata = held.wdata;
            end
        end
    end

    // vld_pipe[0] marks the cycle mem_rdata carries VGA data; [STAGES] is the registered strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe    <= '0;
            vga_rd_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], vga_rd_req};
            if (vld_pipe[0]) vga_rd_data <= mem_rdata;
        end
    end

    assign vga_rd_valid = vld_pipe[STAGES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= C_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            C_IDLE:  if (cpu_req) state_nxt = C_WAIT;
            C_WAIT:  if (grant) state_nxt = held.we ? C_ACK : C_RDATA;
            C_RDATA: state_nxt = C_ACK;
            C_ACK:   state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        cpu_ack = (state == C_ACK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held           <= '0;
            cpu_rdata      <= '0;
            contention_cnt <= '0;
        end else begin
            if (state == C_IDLE && cpu_req) begin
                held.we    <= cpu_we;
                held.addr  <= cpu_addr;
                held.wdata <= cpu_wdata;
            end
            if (state == C_RDATA) cpu_rdata <= mem_rdata;
            // every denied C_WAIT cycle counts, whether lost to VGA or to active video
            if (state == C_WAIT && !grant && contention_cnt != {CNT_W{1'b1}})
                contention_cnt <= contention_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: RAM model, event-scheduled reference model, directed and random stimulus.
module tb_fb_access_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        vga_rd_req = 1'b0;
    logic [15:0] vga_rd_addr = '0;
    logic [15:0] vga_rd_data;
    logic        vga_rd_valid;
    logic        vga_blank_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] contention_cnt;

    fb_access_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
        .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid),
        .vga_blank_n(vga_blank_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .contention_cnt(contention_cnt)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM: contents start as data=addr except one seeded word
    logic [15:0] ram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'(i);
        ram[16'h0042] = 16'h5A5A;
    end
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // reference model: memory image, expected VGA returns, one outstanding CPU transaction
    logic [15:0] ref_mem [int];
    int          q_t[$];
    logic [15:0] q_d[$];
    logic [15:0] obs_vga[$];
    int          cyc = 0;
    bit          m_pend = 0, m_granted = 0, m_we = 0;
    int          m_cap = 0, m_ack_t = 0;
    logic [15:0] m_addr = '0, m_wd = '0, m_rd_val = '0, m_rdata = '0;
    logic [15:0] m_cnt = '0;
    bit          last_ack = 0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return (a == 16'h0042) ? 16'h5A5A : a;
    endfunction

    always @(negedge clock) begin
        bit waiting, elig, grant, e_ack;
        if (!reset) begin
            chk("rst_vga_valid", 32'(vga_rd_valid), 0);
            chk("rst_vga_data",  32'(vga_rd_data), 0);
            chk("rst_cpu_ack",   32'(cpu_ack), 0);
            chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
            chk("rst_cnt",       32'(contention_cnt), 0);
            chk("rst_mem_en",    32'(mem_en), 0);
            chk("rst_mem_we",    32'(mem_we), 0);
            q_t.delete(); q_d.delete();
            m_pend = 0; m_granted = 0; m_cnt = '0; m_rdata = '0;
            last_ack = 0;
        end else begin
            waiting = m_pend && (cyc > m_cap) && !m_granted;
`ifdef FB_VBLANK_WRITE_EN
            elig = !m_we || !vga_blank_n;
`else
            elig = 1'b1;
`endif
            grant = waiting && !vga_rd_req && elig;

            if (vga_rd_req) begin
                chk("vga_issue_en",   32'(mem_en), 1);
                chk("vga_issue_we",   32'(mem_we), 0);
                chk("vga_issue_addr", 32'(mem_addr), 32'(vga_rd_addr));
            end else if (grant) begin
                chk("cpu_issue_en",   32'(mem_en), 1);
                chk("cpu_issue_we",   32'(mem_we), 32'(m_we));
                chk("cpu_issue_addr", 32'(mem_addr), 32'(m_addr));
                if (m_we) chk("cpu_issue_wdata", 32'(mem_wdata), 32'(m_wd));
            end else begin
                chk("idle_mem_en", 32'(mem_en), 0);
            end

            if (q_t.size() > 0 && q_t[0] == cyc) begin
                chk("vga_valid", 32'(vga_rd_valid), 1);
                chk("vga_data",  32'(vga_rd_data), 32'(q_d[0]));
                void'(q_t.pop_front()); void'(q_d.pop_front());
            end else begin
                chk("vga_valid", 32'(vga_rd_valid), 0);
            end
            if (vga_rd_valid) obs_vga.push_back(vga_rd_data);

            e_ack = m_granted && (cyc == m_ack_t);
            if (e_ack && !m_we) m_rdata = m_rd_val;
            chk("cpu_ack",   32'(cpu_ack), 32'(e_ack));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
            chk("cont_cnt",  32'(contention_cnt), 32'(m_cnt));
            last_ack = cpu_ack;

            if (vga_rd_req) begin
                q_t.push_back(cyc + 2);
                q_d.push_back(rd(vga_rd_addr));
            end
            if (waiting && !grant && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (grant) begin
                m_granted = 1;
                m_ack_t   = cyc + (m_we ? 1 : 2);
                if (m_we) ref_mem[int'(m_addr)] = m_wd;
                else      m_rd_val = rd(m_addr);
            end
            if (e_ack) begin
                m_pend = 0; m_granted = 0;
            end else if (!m_pend && cpu_req) begin
                m_pend = 1; m_cap = cyc;
                m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata;
            end
        end
        cyc++;
    end

    task automatic cyc_t();
        @(posedge clock); #1;
    endtask

    initial begin
        int wcyc;
        bit acked;
        logic [15:0] c0;

        // reset and idle
        repeat (3) cyc_t();
        reset = 1'b1;
        repeat (5) cyc_t();
        #1;
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_cnt", 32'(contention_cnt), 0);
        chk("idle_valid", 32'(vga_rd_valid), 0);

        // VGA stream 0x0100..0x0107
        obs_vga.delete();
        for (int i = 0; i < 8; i++) begin
            cyc_t();
            vga_rd_req = 1'b1; vga_rd_addr = 16'h0100 + 16'(i);
        end
        cyc_t(); vga_rd_req = 1'b0;
        repeat (4) cyc_t();
        chk("stream_len", 32'(obs_vga.size()), 8);
        for (int i = 0; i < 8 && i < obs_vga.size(); i++)
            chk("stream_data", 32'(obs_vga[i]), 32'h0100 + 32'(i));

        // uncontended CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'hBEEF;
        cyc_t(); #1;
        chk("wr_grant_we",   32'(mem_we), 1);
        chk("wr_grant_addr", 32'(mem_addr), 32'h1234);
        chk("wr_grant_data", 32'(mem_wdata), 32'hBEEF);
        cyc_t(); #1;
        chk("wr_ack", 32'(cpu_ack), 1);
        chk("wr_cnt", 32'(contention_cnt), 0);
        cpu_req = 1'b0;
        repeat (2) cyc_t();

        // CPU read held off by 6 VGA cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        for (int i = 0; i < 6; i++) begin
            cyc_t();
            vga_rd_req = 1'b1; vga_rd_addr = 16'h0200 + 16'(i);
            #1 chk("rd_blocked_addr", 32'(mem_addr), 32'h0200 + 32'(i));
        end
        cyc_t(); vga_rd_req = 1'b0;
        #1;
        chk("rd_grant_en",   32'(mem_en), 1);
        chk("rd_grant_we",   32'(mem_we), 0);
        chk("rd_grant_addr", 32'(mem_addr), 32'h0042);
        cyc_t(); #1 chk("rd_no_early_ack", 32'(cpu_ack), 0);
        cyc_t(); #1;
        chk("rd_ack",   32'(cpu_ack), 1);
        chk("rd_data",  32'(cpu_rdata), 32'h5A5A);
        chk("rd_cnt",   32'(contention_cnt), 6);
        cpu_req = 1'b0;
        repeat (2) cyc_t();

        // reset while CPU waits and a VGA read is in flight
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'h1111;
        vga_rd_req = 1'b1; vga_rd_addr = 16'h0100;
        cyc_t();
        cyc_t(); reset = 1'b0; vga_rd_req = 1'b0; cpu_req = 1'b0;
        cyc_t(); cyc_t(); reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mrst_ack",   32'(cpu_ack), 0);
            chk("mrst_valid", 32'(vga_rd_valid), 0);
            chk("mrst_cnt",   32'(contention_cnt), 0);
            cyc_t();
        end

        // CPU write pending through 10 active-video cycles
        vga_blank_n = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 16'hCAFE;
        c0 = contention_cnt; wcyc = -1; acked = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc_t();
            if (i == 11) vga_blank_n = 1'b0;
            #1;
            if (mem_en && mem_we && wcyc < 0) wcyc = i;
            if (cpu_ack) begin acked = 1; cpu_req = 1'b0; end
        end
        chk("blank_acked", 32'(acked), 1);
`ifdef FB_VBLANK_WRITE_EN
        chk("blank_wr_cycle", 32'(wcyc), 11);
        chk("blank_cnt", 32'(contention_cnt - c0), 10);
`else
        chk("blank_wr_cycle", 32'(wcyc), 1);
        chk("blank_cnt", 32'(contention_cnt - c0), 0);
`endif
        cpu_req = 1'b0;
        repeat (2) cyc_t();

        // randomized traffic on a small shared address window
        for (int i = 0; i < 3000; i++) begin
            cyc_t();
            vga_rd_req  = ($urandom_range(0, 99) < 55);
            vga_rd_addr = 16'h0040 + 16'($urandom_range(0, 15));
            vga_blank_n = ($urandom_range(0, 3) != 0);
            if (cpu_req && last_ack) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && !last_ack && $urandom_range(0, 3) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 16'h0040 + 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
        end
        vga_rd_req = 1'b0; vga_blank_n = 1'b0;
        for (int i = 0; i < 20 && cpu_req; i++) begin
            cyc_t();
            if (last_ack) cpu_req = 1'b0;
        end
        chk("drain_cpu_done", 32'(cpu_req), 0);
        cpu_req = 1'b0;
        repeat (4) cyc_t();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
